fetch_unit: RTL and testbench

// - Instruction fetch stage, directly upstream of the instruction memory.
// - Owns the program counter and drives the imem address.
// - Captures the imem combinational read data into a small prefetch FIFO.
// - Hands {pc, instr} pairs to decode over a valid/ready handshake.
// - Supports stall via backpressure, fetch enable, and PC redirect (branch/jump) with flush.

---
 rtl/fetch_unit_if.sv | 31 +++
 rtl/fetch_unit.sv | 76 +++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-side bus: imem address/data plus the decode valid/ready handshake.
// master = fetch_unit (drives imem_pc and out_*), slave = imem/decode side.
interface fetch_unit_if #(
  parameter int n = 16,
  parameter int r = 3
);
  logic [r-1:0] imem_pc;
  logic [n-1:0] imem_instr;
  logic         out_valid;
  logic         out_ready;
  logic [n-1:0] out_instr;
  logic [r-1:0] out_pc;

  modport master (
    output imem_pc,
    input  imem_instr,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_pc,
    output imem_instr,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns PC, reads imem, buffers {pc,instr} in a prefetch FIFO.
// Ports: clk, reset (sync high), fetch_en, redirect_valid/pc, count, bus.
module fetch_unit #(
  parameter int n        = 16,
  parameter int r        = 3,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [r-1:0]               redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  fetch_unit_if.master               bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [r-1:0]  pc;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic [n-1:0]  buf_instr [DEPTH];
  logic [r-1:0]  buf_pc    [DEPTH];
  logic          valid;
  logic          pop;
  logic          push;

  assign valid = (cnt != '0);
  assign pop   = valid & bus.out_ready;
  // A full FIFO can still accept when its head leaves this cycle.
  assign push  = fetch_en & ~redirect_valid
               & ((cnt != FULL) | pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= r'(RESET_PC);
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (redirect_valid) begin
      pc     <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        pc     <= pc + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_instr[wr_ptr] <= bus.imem_instr;
      buf_pc[wr_ptr]    <= pc;
    end
  end

  assign bus.imem_pc   = pc;
  assign bus.out_valid = valid;
  assign bus.out_instr = valid ? buf_instr[rd_ptr] : '0;
  assign bus.out_pc    = valid ? buf_pc[rd_ptr] : '0;
  assign count         = cnt;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed table, corner sequences, random vs queue model.
// ROM[a] = 16'h1000 + a, n=16, r=3, DEPTH=4.
module tb_fetch_unit;
  logic       clk = 1'b0;
  logic       reset;
  logic       fetch_en;
  logic       redirect_valid;
  logic [2:0] redirect_pc;
  logic [2:0] count;

  int checks = 0;
  int fails  = 0;

  fetch_unit_if #(.n(16), .r(3)) bus ();

  fetch_unit #(
    .n(16), .r(3), .DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .count          (count),
    .bus            (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = 16'h1000 + {13'd0, bus.imem_pc};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int p,
                         input int ins, input int c, input int ipc);
    chk({tag, ".out_valid"}, int'(bus.out_valid), v);
    chk({tag, ".out_pc"}, int'(bus.out_pc), p);
    chk({tag, ".out_instr"}, int'(bus.out_instr), ins);
    chk({tag, ".count"}, int'(count), c);
    chk({tag, ".imem_pc"}, int'(bus.imem_pc), ipc);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetch_en = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 3'd0;
    bus.out_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic en;
    logic rdy;
    logic rv;
    int   rpc;
    int   v;
    int   p;
    int   ins;
    int   c;
    int   ipc;
  } vec_t;

  vec_t tbl[15];

  typedef struct {
    int pc;
    int instr;
  } ent_t;

  ent_t q[$];
  int   mpc;

  initial begin
    // Directed path from reset: fill, full stall, swap, redirect, wrap.
    tbl[0]  = '{1,0,0,0, 1,0,'h1000,1,1};
    tbl[1]  = '{1,0,0,0, 1,0,'h1000,2,2};
    tbl[2]  = '{1,0,0,0, 1,0,'h1000,3,3};
    tbl[3]  = '{1,0,0,0, 1,0,'h1000,4,4};
    tbl[4]  = '{1,0,0,0, 1,0,'h1000,4,4};
    tbl[5]  = '{1,1,0,0, 1,1,'h1001,4,5};
    tbl[6]  = '{0,1,0,0, 1,2,'h1002,3,5};
    tbl[7]  = '{1,1,1,5, 0,0,0,0,5};
    tbl[8]  = '{1,0,0,0, 1,5,'h1005,1,6};
    tbl[9]  = '{1,1,0,0, 1,6,'h1006,1,7};
    tbl[10] = '{1,1,0,0, 1,7,'h1007,1,0};
    tbl[11] = '{1,1,0,0, 1,0,'h1000,1,1};
    tbl[12] = '{1,0,1,2, 0,0,0,0,2};
    tbl[13] = '{1,0,1,3, 0,0,0,0,3};
    tbl[14] = '{0,0,0,0, 0,0,0,0,3};

    @(negedge clk);
    do_reset();
    chk_out("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      fetch_en       = tbl[i].en;
      bus.out_ready  = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = 3'(tbl[i].rpc);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].p,
              tbl[i].ins, tbl[i].c, tbl[i].ipc);
    end

    // Full FIFO with ready: swap each cycle, order kept.
    redirect_valid = 1'b0;
    do_reset();
    fetch_en = 1'b1;
    bus.out_ready = 1'b0;
    repeat (4) step();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("swap%0d.pc", k), int'(bus.out_pc), k);
      chk($sformatf("swap%0d.count", k), int'(count), 4);
      step();
    end

    // Mid-stream reset with count=3.
    do_reset();
    fetch_en = 1'b1;
    bus.out_ready = 1'b0;
    repeat (3) step();
    chk("pre_rst.count", int'(count), 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    fetch_en = 1'b0;
    chk_out("mid_rst", 0, 0, 0, 0, 0);

    // Random traffic against a queue model.
    do_reset();
    q.delete();
    mpc = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd.out_valid", int'(bus.out_valid), int'(q.size() > 0));
      chk("rnd.count", int'(count), q.size());
      chk("rnd.imem_pc", int'(bus.imem_pc), mpc);
      if (q.size() > 0) begin
        chk("rnd.out_pc", int'(bus.out_pc), q[0].pc);
        chk("rnd.out_instr", int'(bus.out_instr), q[0].instr);
      end else begin
        chk("rnd.out_pc0", int'(bus.out_pc), 0);
        chk("rnd.out_instr0", int'(bus.out_instr), 0);
      end

      reset          = ($urandom_range(99) == 0);
      fetch_en       = ($urandom_range(9) < 8);
      bus.out_ready  = ($urandom_range(9) < 6);
      redirect_valid = ($urandom_range(19) == 0);
      redirect_pc    = 3'($urandom_range(7));

      if (reset) begin
        q.delete();
        mpc = 0;
      end else if (redirect_valid) begin
        q.delete();
        mpc = int'(redirect_pc);
      end else begin
        bit do_pop;
        bit do_push;
        do_pop  = (q.size() > 0) && bus.out_ready;
        do_push = fetch_en && ((q.size() < 4) || do_pop);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          q.push_back('{mpc, 'h1000 + mpc});
          mpc = (mpc + 1) % 8;
        end
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
